// File: rtl/nav_arb_pkg.sv
// Shared types and helpers for the navigate command arbiter.
// Source indices name the fixed command sources; planners added later take higher indices.
package nav_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDNG = 2'd1,
    MOVE = 2'd2
  } arb_state_t;

  localparam int SRC_CMD = 0;
  localparam int SRC_SLV = 1;

  // Width of a source index; never narrower than one bit.
  function automatic int SRC_W(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nav_wdog.sv
// Saturating busy-cycle counter for the move watchdog.
// The terminal-count output is combinational and is qualified by the enable input.
module nav_wdog #(
  parameter int               TMO_W   = 24,
  parameter logic [TMO_W-1:0] TMO_CYC = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [TMO_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + TMO_W'(1);
    end
  end

  assign tc = en && (cnt_reg == (TMO_CYC - TMO_W'(1)));

endmodule

// File: rtl/nav_cmd_arb.sv
// Arbiter granting one command source at a time ownership of the navigate unit.
// Ownership is locked for a whole heading/move operation; a watchdog aborts stuck moves.
module nav_cmd_arb
  import nav_arb_pkg::*;
#(
  parameter int               NUM_SRC = 2,
  parameter int               HDNG_W  = 12,
  parameter int               TMO_W   = 24,
  parameter logic [TMO_W-1:0] TMO_CYC = 24'hFFFFFF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(NUM_SRC)-1:0]   src_sel,
  input  logic [NUM_SRC*HDNG_W-1:0]    src_dsrd_hdng,
  input  logic [NUM_SRC-1:0]           src_strt_hdng,
  input  logic [NUM_SRC-1:0]           src_strt_mv,
  input  logic [NUM_SRC-1:0]           src_stp_lft,
  input  logic [NUM_SRC-1:0]           src_stp_rght,
  input  logic                         mv_cmplt,
  input  logic                         clr_err,
  output logic [HDNG_W-1:0]            nav_dsrd_hdng,
  output logic                         nav_strt_hdng,
  output logic                         nav_strt_mv,
  output logic                         nav_stp_lft,
  output logic                         nav_stp_rght,
  output logic [NUM_SRC-1:0]           src_mv_cmplt,
  output logic [$clog2(NUM_SRC)-1:0]   owner,
  output logic                         busy,
  output logic                         rej,
  output logic                         tmo_err
);

  localparam int SW = SRC_W(NUM_SRC);

  arb_state_t          state_reg, state_next;
  logic [SW-1:0]       owner_reg, owner_next;
  logic [HDNG_W-1:0]   hdng_reg, hdng_next;
  logic                stp_lft_reg, stp_lft_next;
  logic                stp_rght_reg, stp_rght_next;
  logic                strt_hdng_reg, strt_hdng_next;
  logic                strt_mv_reg, strt_mv_next;
  logic [NUM_SRC-1:0]  cmplt_reg, cmplt_next;
  logic                rej_reg, rej_next;
  logic                tmo_err_reg, tmo_err_next;
  logic                busy_reg;

  logic [NUM_SRC-1:0]  owner_onehot;
  logic [HDNG_W-1:0]   hdng_masked [NUM_SRC];
  logic [HDNG_W-1:0]   own_hdng;
  logic                own_strt_hdng, own_strt_mv, own_stp_lft, own_stp_rght;
  logic                other_start, any_start, sel_ok;
  logic                wdog_clr, wdog_tc, tmo_set;

  // One-hot owner decode lets every per-source select be a plain AND-OR.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign owner_onehot[gi] = (owner_reg == SW'(gi));
      assign hdng_masked[gi]  = owner_onehot[gi] ? src_dsrd_hdng[gi*HDNG_W +: HDNG_W] : '0;
    end
  endgenerate

  always_comb begin
    own_hdng = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      own_hdng = own_hdng | hdng_masked[i];
    end
  end

  assign own_strt_hdng = |(src_strt_hdng & owner_onehot);
  assign own_strt_mv   = |(src_strt_mv & owner_onehot);
  assign own_stp_lft   = |(src_stp_lft & owner_onehot);
  assign own_stp_rght  = |(src_stp_rght & owner_onehot);
  assign other_start   = |((src_strt_hdng | src_strt_mv) & ~owner_onehot);
  assign any_start     = |(src_strt_hdng | src_strt_mv);
  assign sel_ok        = (32'(src_sel) < NUM_SRC);

  nav_wdog #(
    .TMO_W   (TMO_W),
    .TMO_CYC (TMO_CYC)
  ) u_wdog (
    .clk (clk),
    .rst (rst),
    .clr (wdog_clr),
    .en  (state_reg != IDLE),
    .tc  (wdog_tc)
  );

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    hdng_next      = hdng_reg;
    stp_lft_next   = stp_lft_reg;
    stp_rght_next  = stp_rght_reg;
    strt_hdng_next = 1'b0;
    strt_mv_next   = 1'b0;
    cmplt_next     = '0;
    rej_next       = 1'b0;
    tmo_set        = 1'b0;
    wdog_clr       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (own_strt_hdng) begin
          // Heading wins over a simultaneous move from the same owner.
          hdng_next      = own_hdng;
          strt_hdng_next = 1'b1;
          wdog_clr       = 1'b1;
          state_next     = HDNG;
          rej_next       = own_strt_mv | other_start;
        end else if (own_strt_mv) begin
          hdng_next     = own_hdng;
          stp_lft_next  = own_stp_lft;
          stp_rght_next = own_stp_rght;
          strt_mv_next  = 1'b1;
          wdog_clr      = 1'b1;
          state_next    = MOVE;
          rej_next      = other_start;
        end else begin
          // Owner only follows src_sel while no operation is being launched.
          rej_next = other_start;
          if (sel_ok) begin
            owner_next = SW'(src_sel);
          end
        end
      end
      HDNG, MOVE: begin
        rej_next = any_start;
        if (mv_cmplt) begin
          cmplt_next    = owner_onehot;
          stp_lft_next  = 1'b0;
          stp_rght_next = 1'b0;
          state_next    = IDLE;
        end else if (wdog_tc) begin
          tmo_set       = 1'b1;
          stp_lft_next  = 1'b0;
          stp_rght_next = 1'b0;
          state_next    = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    tmo_err_next = tmo_set ? 1'b1 : (clr_err ? 1'b0 : tmo_err_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      owner_reg     <= SW'(SRC_CMD);
      hdng_reg      <= '0;
      stp_lft_reg   <= 1'b0;
      stp_rght_reg  <= 1'b0;
      strt_hdng_reg <= 1'b0;
      strt_mv_reg   <= 1'b0;
      cmplt_reg     <= '0;
      rej_reg       <= 1'b0;
      tmo_err_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      hdng_reg      <= hdng_next;
      stp_lft_reg   <= stp_lft_next;
      stp_rght_reg  <= stp_rght_next;
      strt_hdng_reg <= strt_hdng_next;
      strt_mv_reg   <= strt_mv_next;
      cmplt_reg     <= cmplt_next;
      rej_reg       <= rej_next;
      tmo_err_reg   <= tmo_err_next;
      busy_reg      <= (state_next != IDLE);
    end
  end

  assign nav_dsrd_hdng = hdng_reg;
  assign nav_strt_hdng = strt_hdng_reg;
  assign nav_strt_mv   = strt_mv_reg;
  assign nav_stp_lft   = stp_lft_reg;
  assign nav_stp_rght  = stp_rght_reg;
  assign src_mv_cmplt  = cmplt_reg;
  assign owner         = owner_reg;
  assign busy          = busy_reg;
  assign rej           = rej_reg;
  assign tmo_err       = tmo_err_reg;

endmodule
